// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter that owns the select lines of a shared 8:1 mux.
// Each grant is held for at most MAX_HOLD consecutive cycles, then the
// search start moves past the grantee so no requester can starve the rest.
// The selected data bit is registered one cycle behind the grant.
//
// Parameters:
//   MAX_HOLD  max consecutive cycles one grant is held (legal 1..15)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      request vector, req[k] = requester k wants the path
//   data_in  mux data inputs, bit k belongs to requester k
//   sel      registered mux select (current / last grantee)
//   gnt      registered one-hot grant, 0 when idle
//   busy     high while a grant is active (gnt != 0)
//   y_out    registered data_in[sel], captured on granted cycles
//   y_valid  high in the cycle after each granted cycle
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       y_out,
    output logic       y_valid
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [2:0] sel_d;
    logic [7:0] gnt_d;
    logic       y_out_d, y_valid_d;

    // {found, index} of the first set request at or after start, wrapping.
    logic [3:0] pick_ptr;
    logic [3:0] pick_next;

    function automatic logic [3:0] rr_pick(input logic [7:0] r,
                                           input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick_ptr  = rr_pick(req, ptr_q);
        pick_next = rr_pick(req, sel + 3'd1);

        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        sel_d     = sel;
        gnt_d     = gnt;
        y_out_d   = y_out;
        y_valid_d = 1'b0;

        // Data capture keys off the grant that was active before this edge.
        if (gnt != '0) begin
            y_out_d   = data_in[sel];
            y_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_ptr[3]) begin
                    sel_d   = pick_ptr[2:0];
                    gnt_d   = 8'd1 << pick_ptr[2:0];
                    hold_d  = 4'd1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (req[sel] && (hold_q < MAX_HOLD_C)) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    // Release and re-arbitrate in the same edge so that
                    // back-to-back grants leave no idle cycle.
                    ptr_d = sel + 3'd1;
                    if (pick_next[3]) begin
                        sel_d  = pick_next[2:0];
                        gnt_d  = 8'd1 << pick_next[2:0];
                        hold_d = 4'd1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            sel     <= '0;
            gnt     <= '0;
            y_out   <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            sel     <= sel_d;
            gnt     <= gnt_d;
            y_out   <= y_out_d;
            y_valid <= y_valid_d;
        end
    end

    assign busy = (gnt != '0);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Self-checking bench for rr_mux_arbiter (MAX_HOLD = 4). A behavioural
// model tracks the current grantee, burst length and search pointer as
// plain integers; every cycle the DUT outputs are compared against it.
// Directed scenarios add fixed expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y_out;
    logic       y_valid;

    int n_checks;
    int n_pass;

    // Reference model state
    int m_ptr;
    int m_sel;
    int m_cnt;
    bit m_busy;
    bit m_yout;
    bit m_yval;

    rr_mux_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .y_out   (y_out),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int scan(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_gnt();
        return m_busy ? (8'd1 << m_sel) : 8'd0;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_sel  = 0;
        m_cnt  = 0;
        m_busy = 0;
        m_yout = 0;
        m_yval = 0;
    endtask

    task automatic model_edge();
        int w;
        if (m_busy) begin
            m_yout = data_in[m_sel];
            m_yval = 1;
        end else begin
            m_yval = 0;
        end
        if (!m_busy) begin
            w = scan(req, m_ptr);
            if (w >= 0) begin
                m_sel  = w;
                m_busy = 1;
                m_cnt  = 1;
            end
        end else if (req[m_sel] && m_cnt < MH) begin
            m_cnt++;
        end else begin
            m_ptr = (m_sel + 1) % 8;
            w = scan(req, m_ptr);
            if (w >= 0) begin
                m_sel = w;
                m_cnt = 1;
            end else begin
                m_busy = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("sel",     32'(sel),     32'(m_sel));
        check_eq("gnt",     32'(gnt),     32'(m_gnt()));
        check_eq("busy",    32'(busy),    32'(m_busy));
        check_eq("y_out",   32'(y_out),   32'(m_yout));
        check_eq("y_valid", 32'(y_valid), 32'(m_yval));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then sample the DUT 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset from the current time; outputs must clear at once.
    task automatic do_reset(input int held_edges);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (held_edges) begin
            req     = 8'($urandom);
            data_in = 8'($urandom);
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        req      = '0;
        data_in  = '0;
        rst_n    = 1'b0;
        model_reset();

        // Reset with random inputs, then release with no requests
        do_reset(3);
        req = '0;
        repeat (3) cycle();
        check_eq("idle_gnt", 32'(gnt), 32'h0);

        // Single requester holds continuously across burst reloads
        req = 8'h08;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'($urandom);
            cycle();
            check_eq("single_gnt", 32'(gnt), 32'h08);
            check_eq("single_sel", 32'(sel), 32'd3);
        end

        // Full contention: each index granted for exactly MH cycles in turn
        do_reset(0);
        req = 8'hFF;
        for (int n = 0; n < 8 * MH + 2; n++) begin
            data_in = 8'($urandom);
            cycle();
            check_eq("rot_sel", 32'(sel), 32'((n / MH) % 8));
        end

        // Pointer fairness: after 2 releases, 5 beats 2, then 2 follows
        do_reset(0);
        req = 8'h04;
        cycle();
        check_eq("fair_g2", 32'(gnt), 32'h04);
        req = 8'h00;
        cycle();
        req = 8'h24;
        cycle();
        check_eq("fair_g5", 32'(gnt), 32'h20);
        repeat (MH - 1) cycle();
        check_eq("fair_g5_end", 32'(gnt), 32'h20);
        cycle();
        check_eq("fair_g2_again", 32'(gnt), 32'h04);

        // Early drop by grantee 6, then wrap from ptr 7 to grant 0
        do_reset(0);
        req = 8'h40;
        cycle();
        check_eq("drop_g6", 32'(gnt), 32'h40);
        cycle();
        req = 8'h00;
        cycle();
        check_eq("drop_gnt0", 32'(gnt), 32'h0);
        check_eq("drop_busy0", 32'(busy), 32'h0);
        req = 8'h41;
        cycle();
        check_eq("wrap_g0", 32'(gnt), 32'h01);

        // Data path on grantee 1, reset mid-burst, restart from ptr 0
        do_reset(0);
        req = 8'h02;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'($urandom);
            data_in[1] = i[0];
            cycle();
        end
        check_eq("data_valid", 32'(y_valid), 32'h1);
        do_reset(0);
        req = 8'h80;
        cycle();
        check_eq("restart_g7", 32'(gnt), 32'h80);
        check_eq("restart_sel", 32'(sel), 32'd7);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: req = 8'($urandom);
                1: req = 8'($urandom) & 8'($urandom) & 8'($urandom);
                2: req = req;
                default: req = (8'($urandom_range(0, 1)) << $urandom_range(0, 7));
            endcase
            data_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                do_reset(0);
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
